// File: rtl/dwt_pkg.sv
// -----------------------------------------------------------------------------
// dwt_pkg
// Shared definitions for the DWT lifting-scheme control blocks.
//   CNT_W_DEF : default width of the upstream sample counter.
//   ST_*      : FSM state encodings (plain constants so legacy code can use them).
// -----------------------------------------------------------------------------
package dwt_pkg;

  localparam int CNT_W_DEF = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_FLUSH  = 2'd2;

endpackage : dwt_pkg

// File: rtl/controller2.sv
// -----------------------------------------------------------------------------
// controller2
// Control/sequencing for the second lifting stage of the DWT datapath.
// Decodes sample parity, steers the even-sample buffer, and generates the
// detail/coarse strobes, including the flush phase after input ends.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset
//   count[CNT_W-1:0]    upstream sample index, bit 0 is parity
//   valid_in            new input sample this cycle
//   internal_valid      flush/drain cycle (ignored when valid_in is high)
//   iseven              count is even (combinational, valid during reset)
//   valid_detailOut     detail coefficient valid (registered)
//   valid_coarseOut     coarse coefficient valid (registered)
//   coarse_coeff_wr_en  write detail into coarse-update buffer (registered)
//   even_rd_en          read stored even sample (combinational)
//   even_wr_en          store current even sample (combinational)
// -----------------------------------------------------------------------------
module controller2
  import dwt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count,
  input  logic             valid_in,
  input  logic             internal_valid,
  output logic             iseven,
  output logic             valid_detailOut,
  output logic             valid_coarseOut,
  output logic             coarse_coeff_wr_en,
  output logic             even_rd_en,
  output logic             even_wr_en
);

  state_t state_q, state_d;
  logic   have_prev_q, have_prev_d;
  logic   valid_detail_q, valid_detail_d;
  logic   valid_coarse_q, valid_coarse_d;
  logic   coarse_wr_q, coarse_wr_d;
  logic   any_valid;
  logic   enter_idle;

  // Only the parity bit matters; the upper count bits are intentionally unused.
  logic unused_count;
  assign unused_count = ^count[CNT_W-1:1];

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d        = state_q;
    have_prev_d    = have_prev_q;

    iseven         = ~count[0];
    // valid_in wins over internal_valid; both lead to the same odd-sample work.
    any_valid      = valid_in | internal_valid;
    even_wr_en     = ~rst & valid_in & iseven;
    even_rd_en     = ~rst & any_valid & ~iseven;

    valid_detail_d = valid_in & ~iseven;
    coarse_wr_d    = any_valid & ~iseven;
    // The first detail of a frame has no predecessor to pair with.
    valid_coarse_d = coarse_wr_q & have_prev_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (valid_in)            state_d = ST_ACTIVE;
        else if (internal_valid) state_d = ST_FLUSH;
        else                     state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (valid_in)            state_d = ST_ACTIVE;
        else if (internal_valid) state_d = ST_FLUSH;
        else                     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Returning to IDLE ends the frame, so the pairing history is dropped.
    enter_idle = (state_d == ST_IDLE) && (state_q != ST_IDLE);
    if (enter_idle)       have_prev_d = 1'b0;
    else if (coarse_wr_q) have_prev_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q        <= ST_IDLE;
      have_prev_q    <= 1'b0;
      valid_detail_q <= 1'b0;
      valid_coarse_q <= 1'b0;
      coarse_wr_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      have_prev_q    <= have_prev_d;
      valid_detail_q <= valid_detail_d;
      valid_coarse_q <= valid_coarse_d;
      coarse_wr_q    <= coarse_wr_d;
    end
  end

  assign valid_detailOut    = valid_detail_q;
  assign valid_coarseOut    = valid_coarse_q;
  assign coarse_coeff_wr_en = coarse_wr_q;

endmodule : controller2

// File: tb/tb_controller2.sv
// -----------------------------------------------------------------------------
// tb_controller2
// Directed, table-driven bench for controller2. Each row drives one cycle of
// inputs, checks the combinational enables before the edge and the registered
// strobes just after it. A hand-written sequence covers the frame-end clear of
// the pairing history.
// -----------------------------------------------------------------------------
module tb_controller2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] count;
  logic       valid_in;
  logic       internal_valid;
  logic       iseven;
  logic       valid_detailOut;
  logic       valid_coarseOut;
  logic       coarse_coeff_wr_en;
  logic       even_rd_en;
  logic       even_wr_en;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  controller2 #(.CNT_W(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .count              (count),
    .valid_in           (valid_in),
    .internal_valid     (internal_valid),
    .iseven             (iseven),
    .valid_detailOut    (valid_detailOut),
    .valid_coarseOut    (valid_coarseOut),
    .coarse_coeff_wr_en (coarse_coeff_wr_en),
    .even_rd_en         (even_rd_en),
    .even_wr_en         (even_wr_en)
  );

  // Inputs for one cycle, the same-cycle enables, and the strobes after the edge.
  typedef struct packed {
    logic       rst;
    logic [4:0] cnt;
    logic       vi;
    logic       iv;
    logic       is_even;
    logic       wr;
    logic       rd;
    logic       det;
    logic       cwr;
    logic       cout;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic [4:0] c, input logic vi,
                              input logic iv, input logic e, input logic wr,
                              input logic rd, input logic det, input logic cwr,
                              input logic cout);
    vec_t v;
    v.rst = r;  v.cnt = c;  v.vi = vi;   v.iv = iv;
    v.is_even = e; v.wr = wr; v.rd = rd;
    v.det = det; v.cwr = cwr; v.cout = cout;
    return v;
  endfunction

  task automatic check(input string name, input logic actual, input logic expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    rst            = v.rst;
    count          = v.cnt;
    valid_in       = v.vi;
    internal_valid = v.iv;
    #1;
    check({tag, ".iseven"},     iseven,     v.is_even);
    check({tag, ".even_wr_en"}, even_wr_en, v.wr);
    check({tag, ".even_rd_en"}, even_rd_en, v.rd);
    @(posedge clk);
    #1;
    check({tag, ".valid_detailOut"},    valid_detailOut,    v.det);
    check({tag, ".coarse_coeff_wr_en"}, coarse_coeff_wr_en, v.cwr);
    check({tag, ".valid_coarseOut"},    valid_coarseOut,    v.cout);
  endtask

  initial begin
    rst            = 1'b1;
    count          = 5'd1;
    valid_in       = 1'b1;
    internal_valid = 1'b0;

    //                rst cnt   vi    iv    even  wr    rd    det   cwr   cout
    // Reset held two cycles with an odd valid sample present.
    vecs[0]  = mk(1'b1, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Streaming counts 0..7.
    vecs[2]  = mk(1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 5'd2,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    // Flush counts 8..10.
    vecs[10] = mk(1'b0, 5'd8,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Idle cycle, then a new frame starting at count 1; count 3 collides.
    vecs[13] = mk(1'b0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(1'b0, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 5'd2,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[16] = mk(1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[17] = mk(1'b0, 5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Counter wrap 31 -> 0.
    vecs[18] = mk(1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[19] = mk(1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Reset mid-frame drops the pending coarse strobe and the history.
    vecs[20] = mk(1'b0, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[21] = mk(1'b1, 5'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[23] = mk(1'b0, 5'd4,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end

    // Hand sequence: ACTIVE -> IDLE must clear the history, so the first
    // detail of the following frame makes no coarse strobe.
    step("h0", mk(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step("h1", mk(1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    step("h2", mk(1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("h3", mk(1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    step("h4", mk(1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    step("h5", mk(1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step("h6", mk(1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    step("h7", mk(1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step("h8", mk(1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    step("h9", mk(1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_controller2
